slave_mem_arbiter: RTL and testbench
====================================

# slave_mem_arbiter

Shared-memory controller for an I2C slave device. Owns the device's byte-wide register file and arbitrates it between the I2C slave engine (`req`/`read`/`data` handshake) and a local host port. The I2C side can never be stalled, so it has absolute priority. The host side is served through a request/grant handshake with starvation reporting. The block sits beside `I2C_slave` inside a slave wrapper and replaces ad-hoc memory logic.

## Interface
Parameters:
- `DEPTH`, 8: number of bytes; power of two, ≥2.
- `WIDTH`, 8: byte width.
- `RESET_VAL`, 64'hDEADBEEFDEADBEEF: flat reset image; byte *i* = `RESET_VAL[i*WIDTH +: WIDTH]`.
- `STARVE_MAX`, 4: consecutive deferred host cycles before `host_starve` asserts.

Ports (one clock; reset is synchronous and active-low):
- `SCL` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `i2c_req` in 1: one-cycle byte-transfer strobe from the slave engine.
- `i2c_read` in 1: high = master reading; block drives `data`.
- `data` inout WIDTH: driven with `mem[ptr]` when `i2c_read`=1, else high-Z.
- `i2c_sel` in 1: high while this slave is addressed. Used only with `ARB_PTR_LOAD_EN`.
- `host_req` in 1: host access request, held until granted.
- `host_we` in 1: 1 = write, 0 = read. Sampled with `host_req`.
- `host_addr` in $clog2(DEPTH): host byte address.
- `host_wdata` in WIDTH: host write data.
- `host_gnt` out 1: one-cycle pulse; the host access occurs on this edge.
- `host_rdata` out WIDTH: read data, registered.
- `host_rvalid` out 1: one-cycle pulse, the cycle after a read grant.
- `host_starve` out 1: host deferred ≥ `STARVE_MAX` consecutive cycles.
- `ptr` out $clog2(DEPTH): current I2C pointer.

## Operation
- **I2C write:** `i2c_req`=1 and `i2c_read`=0 → `mem[ptr] <= data`, `ptr <= ptr+1`.
- **I2C read:** `i2c_req`=1 and `i2c_read`=1 → `ptr <= ptr+1`. `data` is combinational from `mem[ptr]`.
- **Pointer wrap:** `ptr` wraps modulo DEPTH (DEPTH-1 → 0).
- **Host FSM** (`slv_arb_state_e`):
  - IDLE: `host_req` & ~`i2c_req` → GRANT; `host_req` & `i2c_req` → WAIT.
  - WAIT: ~`i2c_req` → GRANT, else stay in WAIT.
  - GRANT: `host_gnt`=1 combinational. Write: `mem[host_addr] <= host_wdata`. Read: `host_rdata <= mem[host_addr]`. Next state is RVALID on a read, IDLE on a write.
  - RVALID: `host_rvalid`=1 → IDLE.
  - An `i2c_req` arriving in the same cycle as GRANT still wins. The grant is withdrawn and the FSM returns to WAIT. `host_gnt` is asserted only when `i2c_req`=0, so the two ports never access the array on the same edge.
- **Starvation counter:** saturating; counts cycles in WAIT and clears on grant. `host_starve` = (count ≥ `STARVE_MAX`) and is cleared by the grant.
- **Host write vs. I2C read:** a host write to `mem[ptr]` between I2C read strobes changes `data` immediately. This is allowed; the I2C engine samples `data` at its own strobe.
- **Host de-asserts `host_req` in WAIT:** FSM returns to IDLE with no access.
- **Reset:** mem = `RESET_VAL`, `ptr`=0, FSM=IDLE, `host_gnt`=0, `host_rvalid`=0, `host_rdata`=0, `host_starve`=0, counter=0. A reset mid-handshake aborts with no access.

## Timing
- I2C write latency: 1 edge. Read data is valid combinationally, in the same cycle.
- Host write, uncontended: request in cycle *n* → `host_gnt` in cycle *n+1* → memory updated at the end of *n+1*.
- Host read, uncontended: `host_gnt` in *n+1*, `host_rvalid` with data in *n+2*.
- Contended: the grant occurs in the first cycle with `i2c_req`=0 after WAIT entry.

## Configuration
- **`ARB_PTR_LOAD_EN` defined:**
  - The first I2C write strobe after a rising edge of `i2c_sel` loads `ptr <= data[$clog2(DEPTH)-1:0]` and does not store to memory.
  - Subsequent strobes in the same selection behave normally.
  - A per-selection "first byte" flag is set on `i2c_sel` rise, cleared on the first write strobe, and reset to 0.
- **Not defined:** `i2c_sel` is ignored. Every write strobe stores the byte; the pointer only auto-increments.

## Structure
- **Package `slv_arb_pkg`:** `slv_arb_state_e` (IDLE, WAIT, GRANT, RVALID), the default DEPTH/WIDTH localparams, and the pointer-width function.
- **Sub-module `slv_regfile`:** the DEPTH×WIDTH array with one write port, a combinational I2C read port and a host read port. The arbiter muxes the write port.

## Test plan
- **Reset:** read all 8 bytes via host → EF, BE, AD, DE, EF, BE, AD, DE; `ptr`=0; all outputs 0.
- **I2C auto-increment and wrap:** write 8'h11..8'h19 via 9 I2C write strobes → mem[0]=8'h19, mem[1..7]=8'h12..8'h18, `ptr`=1.
- **Host uncontended:**
  - Write 8'hA5 to address 3 → `host_gnt` one cycle after request.
  - Read address 3 → `host_rdata`=8'hA5 with `host_rvalid` two cycles after request.
- **Contention:**
  - Hold `i2c_req` for 6 cycles while `host_req` is high → `host_gnt` stays 0, `host_starve`=1 from the 4th WAIT cycle.
  - Release `i2c_req` → grant next cycle and `host_starve` clears.
- **Reset during WAIT:** assert `rst_n`=0 with a host write pending → no memory change and FSM in IDLE.
- **With `ARB_PTR_LOAD_EN`:** raise `i2c_sel`, write 8'h05 then 8'h77 → `ptr` loaded to 5, mem[5]=8'h77, `ptr`=6.

Source files
------------

// File: rtl/slv_arb_pkg.sv
// ---------------------------------------------------------------------------
// slv_arb_pkg
// Shared types and helpers for the I2C slave memory arbiter.
//   slv_arb_state_e : host-port handshake FSM states
//   DEF_DEPTH/WIDTH : default register file geometry
//   ptr_w()         : address/pointer width for a given depth
// ---------------------------------------------------------------------------
package slv_arb_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        GRANT  = 2'd2,
        RVALID = 2'd3
    } slv_arb_state_e;

    // Never returns 0 so a degenerate depth still yields a legal vector.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/slv_regfile.sv
// ---------------------------------------------------------------------------
// slv_regfile
// DEPTH x WIDTH byte array with one synchronous write port and two
// combinational read ports (I2C pointer side and host side).
// Ports:
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_we, i_waddr, i_wdata  : single write port (muxed by the arbiter)
//   i_i2c_raddr/o_i2c_rdata : combinational read at the I2C pointer
//   i_host_raddr/o_host_rdata : combinational read at the host address
// Reset loads the flat RESET_VAL image, byte i = RESET_VAL[i*WIDTH +: WIDTH].
// ---------------------------------------------------------------------------
module slv_regfile
    import slv_arb_pkg::*;
#(
    parameter int                     DEPTH     = DEF_DEPTH,
    parameter int                     WIDTH     = DEF_WIDTH,
    parameter logic [DEPTH*WIDTH-1:0] RESET_VAL = '0,
    localparam int                    AW        = ptr_w(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_i2c_raddr,
    output logic [WIDTH-1:0] o_i2c_rdata,
    input  logic [AW-1:0]    i_host_raddr,
    output logic [WIDTH-1:0] o_host_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VAL[i*WIDTH +: WIDTH];
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_i2c_rdata  = r_mem[i_i2c_raddr];
    assign o_host_rdata = r_mem[i_host_raddr];

endmodule

// File: rtl/slave_mem_arbiter.sv
// ---------------------------------------------------------------------------
// slave_mem_arbiter
// Register file owner for an I2C slave. The I2C engine has absolute priority
// (it cannot be stalled); the host port is served by a request/grant FSM with
// a saturating starvation counter.
//
// Handshake (host side): host_req/host_we/host_addr/host_wdata are held
// until host_gnt pulses; the access happens on the edge that ends the
// host_gnt cycle. host_gnt is only ever high while i2c_req is low, so the two
// sides never write the array on the same edge. A read returns data in
// host_rdata with host_rvalid high in the following cycle.
//
// Ports:
//   SCL, rst_n        : clock, synchronous active-low reset
//   i2c_req, i2c_read : byte strobe and direction from the I2C slave engine
//   data              : bidirectional byte bus, driven with mem[ptr] on reads
//   i2c_sel           : slave-selected level (pointer-load build only)
//   host_req/we/addr/wdata : host request
//   host_gnt, host_rdata, host_rvalid, host_starve : host response
//   ptr               : current I2C byte pointer
//   dbg_state         : host FSM state, for observation only
//
// Build option: ARB_PTR_LOAD_EN - first write byte after i2c_sel rises loads
// the pointer instead of being stored.
// ---------------------------------------------------------------------------
module slave_mem_arbiter
    import slv_arb_pkg::*;
#(
    parameter int                     DEPTH      = DEF_DEPTH,
    parameter int                     WIDTH      = DEF_WIDTH,
    parameter logic [DEPTH*WIDTH-1:0] RESET_VAL  = 64'hDEADBEEFDEADBEEF,
    parameter int                     STARVE_MAX = 4,
    localparam int                    AW         = ptr_w(DEPTH)
) (
    input  logic             SCL,
    input  logic             rst_n,
    input  logic             i2c_req,
    input  logic             i2c_read,
    inout  wire  [WIDTH-1:0] data,
    input  logic             i2c_sel,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [WIDTH-1:0] host_wdata,
    output logic             host_gnt,
    output logic [WIDTH-1:0] host_rdata,
    output logic             host_rvalid,
    output logic             host_starve,
    output logic [AW-1:0]    ptr,
    output slv_arb_state_e   dbg_state
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    slv_arb_state_e   r_state;
    slv_arb_state_e   w_next;
    logic             w_gnt;
    logic [AW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_host_rdata;
    logic             w_i2c_wr;
    logic             w_ptr_load;
    logic             w_i2c_store;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_i2c_rdata;
    logic [WIDTH-1:0] w_host_rd;

    assign w_i2c_wr = i2c_req & ~i2c_read;

`ifdef ARB_PTR_LOAD_EN
    logic r_sel_d;
    logic r_first;
    logic w_sel_rise;

    assign w_sel_rise = i2c_sel & ~r_sel_d;
    // A strobe in the very cycle of the select rise is also the first byte.
    assign w_ptr_load = w_i2c_wr & (r_first | w_sel_rise);

    always_ff @(posedge SCL) begin
        if (!rst_n) begin
            r_sel_d <= 1'b0;
            r_first <= 1'b0;
        end else begin
            r_sel_d <= i2c_sel;
            if (w_ptr_load) begin
                r_first <= 1'b0;
            end else if (w_sel_rise) begin
                r_first <= 1'b1;
            end
        end
    end
`else
    logic w_unused_sel;
    assign w_unused_sel = i2c_sel;
    assign w_ptr_load   = 1'b0;
`endif

    assign w_i2c_store = w_i2c_wr & ~w_ptr_load;

    // I2C pointer: load (option) or auto-increment on every strobe; the
    // increment wraps naturally because DEPTH is a power of two.
    always_ff @(posedge SCL) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_ptr_load) begin
            r_ptr <= data[AW-1:0];
        end else if (i2c_req) begin
            r_ptr <= r_ptr + AW'(1);
        end
    end

    // Host FSM state register.
    always_ff @(posedge SCL) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Host FSM next-state and grant. An I2C strobe in GRANT pulls the grant
    // back and returns to WAIT.
    always_comb begin
        w_next = r_state;
        w_gnt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (host_req) begin
                    w_next = i2c_req ? WAIT : GRANT;
                end
            end
            WAIT: begin
                if (!host_req) begin
                    w_next = IDLE;
                end else if (!i2c_req) begin
                    w_next = GRANT;
                end
            end
            GRANT: begin
                if (i2c_req) begin
                    w_next = WAIT;
                end else begin
                    w_gnt  = 1'b1;
                    w_next = host_we ? IDLE : RVALID;
                end
            end
            RVALID: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Starvation counter: counts every cycle that ends with the host still
    // deferred (including the IDLE cycle that enters WAIT), so the flag is
    // up in the STARVE_MAX-th WAIT cycle. Saturates; cleared by the grant or
    // by the host abandoning its request.
    always_ff @(posedge SCL) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_gnt || (w_next == IDLE)) begin
            r_cnt <= '0;
        end else if ((w_next == WAIT) && (r_cnt < CW'(STARVE_MAX))) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge SCL) begin
        if (!rst_n) begin
            r_host_rdata <= '0;
        end else if (w_gnt && !host_we) begin
            r_host_rdata <= w_host_rd;
        end
    end

    // Write port mux; the two sources are exclusive since w_gnt needs
    // i2c_req low.
    assign w_we    = w_i2c_store | (w_gnt & host_we);
    assign w_waddr = w_i2c_store ? r_ptr : host_addr;
    assign w_wdata = w_i2c_store ? data  : host_wdata;

    slv_regfile #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .i_clk        (SCL),
        .i_rst_n      (rst_n),
        .i_we         (w_we),
        .i_waddr      (w_waddr),
        .i_wdata      (w_wdata),
        .i_i2c_raddr  (r_ptr),
        .o_i2c_rdata  (w_i2c_rdata),
        .i_host_raddr (host_addr),
        .o_host_rdata (w_host_rd)
    );

    assign data        = i2c_read ? w_i2c_rdata : {WIDTH{1'bz}};
    assign host_gnt    = w_gnt;
    assign host_rdata  = r_host_rdata;
    assign host_rvalid = (r_state == RVALID);
    assign host_starve = (r_cnt >= CW'(STARVE_MAX));
    assign ptr         = r_ptr;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_slave_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_slave_mem_arbiter
// Directed bench for slave_mem_arbiter (default geometry 8 x 8).
// Honours ARB_PTR_LOAD_EN for the pointer-load scenario.
// ---------------------------------------------------------------------------
module tb_slave_mem_arbiter;
    import slv_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic       SCL = 1'b0;
    logic       rst_n;
    always #5 SCL = ~SCL;

    logic       i2c_req, i2c_read, i2c_sel;
    logic       tb_drv;
    logic [7:0] tb_data;
    wire  [7:0] data;
    logic       host_req, host_we;
    logic [2:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt, host_rvalid, host_starve;
    logic [7:0] host_rdata;
    logic [2:0] ptr;
    slv_arb_state_e dbg_state;

    assign data = tb_drv ? tb_data : 8'hzz;

    slave_mem_arbiter dut (
        .SCL         (SCL),
        .rst_n       (rst_n),
        .i2c_req     (i2c_req),
        .i2c_read    (i2c_read),
        .data        (data),
        .i2c_sel     (i2c_sel),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .host_starve (host_starve),
        .ptr         (ptr),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge SCL);
        #1;
    endtask

    task automatic i2c_write(input logic [7:0] d);
        i2c_req  = 1'b1;
        i2c_read = 1'b0;
        tb_drv   = 1'b1;
        tb_data  = d;
        step();
        i2c_req  = 1'b0;
        tb_drv   = 1'b0;
    endtask

    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        #1 check("hw_gnt_n", 64'(host_gnt), 64'd0);
        step();
        #1 check("hw_gnt_n1", 64'(host_gnt), 64'd1);
        step();
        host_req = 1'b0;
    endtask

    task automatic host_read(input logic [2:0] a, input logic [7:0] exp);
        exp_q.push_back(exp);
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = a;
        #1 check("hr_gnt_n", 64'(host_gnt), 64'd0);
        step();
        #1 check("hr_gnt_n1", 64'(host_gnt), 64'd1);
        step();
        host_req = 1'b0;
        #1 check("hr_rvalid", 64'(host_rvalid), 64'd1);
        check($sformatf("hr_rdata[%0d]", a), 64'(host_rdata), 64'(exp_q.pop_front()));
        step();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [7:0] rst_img [8] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] after_i2c [8] = '{8'h19, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};

    initial begin
        rst_n = 1'b0; i2c_req = 1'b0; i2c_read = 1'b0; i2c_sel = 1'b0;
        tb_drv = 1'b0; tb_data = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        step(); step();
        rst_n = 1'b1;

        // Reset state
        #1;
        check("rst_ptr",    64'(ptr),         64'd0);
        check("rst_gnt",    64'(host_gnt),    64'd0);
        check("rst_rvalid", 64'(host_rvalid), 64'd0);
        check("rst_starve", 64'(host_starve), 64'd0);
        check("rst_rdata",  64'(host_rdata),  64'd0);
        check("rst_state",  64'(dbg_state),   64'(IDLE));
        for (int i = 0; i < 8; i++) host_read(3'(i), rst_img[i]);

        // I2C auto-increment with wrap: 9 strobes into 8 bytes
        for (int i = 0; i < 9; i++) i2c_write(8'h11 + 8'(i));
        #1 check("i2c_ptr_wrap", 64'(ptr), 64'd1);
        i2c_read = 1'b1;
        #1 check("i2c_rd_data", 64'(data), 64'h12);
        i2c_read = 1'b0;
        for (int i = 0; i < 8; i++) host_read(3'(i), after_i2c[i]);

        // Host uncontended
        host_write(3'd3, 8'hA5);
        host_read(3'd3, 8'hA5);

        // Contention: six read strobes hold off a host write
        host_req = 1'b1; host_we = 1'b1; host_addr = 3'd6; host_wdata = 8'h3C;
        i2c_req = 1'b1; i2c_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("ct_gnt[%0d]", k),    64'(host_gnt),    64'd0);
            check($sformatf("ct_starve[%0d]", k), 64'(host_starve), 64'(k >= 4));
            step();
        end
        i2c_req = 1'b0; i2c_read = 1'b0;
        #1;
        check("ct_rel_gnt",    64'(host_gnt),    64'd0);
        check("ct_rel_starve", 64'(host_starve), 64'd1);
        step();
        #1 check("ct_gnt", 64'(host_gnt), 64'd1);
        step();
        host_req = 1'b0;
        #1;
        check("ct_starve_clr", 64'(host_starve), 64'd0);
        check("ct_ptr",        64'(ptr),         64'd7);
        host_read(3'd6, 8'h3C);

        // Reset while a host write waits
        host_req = 1'b1; host_we = 1'b1; host_addr = 3'd2; host_wdata = 8'h99;
        i2c_req = 1'b1; i2c_read = 1'b1;
        step(); step();
        #1 check("rw_state_wait", 64'(dbg_state), 64'(WAIT));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; i2c_req = 1'b0; i2c_read = 1'b0; host_req = 1'b0;
        #1;
        check("rw_state_idle", 64'(dbg_state), 64'(IDLE));
        check("rw_ptr",        64'(ptr),       64'd0);
        check("rw_gnt",        64'(host_gnt),  64'd0);
        step();
        host_read(3'd2, 8'hAD);

        // Select rise followed by two write bytes
        i2c_sel = 1'b1;
        step();
        i2c_write(8'h05);
        i2c_write(8'h77);
        i2c_sel = 1'b0;
`ifdef ARB_PTR_LOAD_EN
        #1 check("pl_ptr", 64'(ptr), 64'd6);
        host_read(3'd5, 8'h77);
        host_read(3'd0, 8'hEF);
`else
        #1 check("pl_ptr", 64'(ptr), 64'd2);
        host_read(3'd0, 8'h05);
        host_read(3'd1, 8'h77);
        host_read(3'd5, 8'hBE);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
